// File: rtl/audio_codec_bridge.sv
// audio_codec_bridge
// Stream adapter between the Audio_Controller pulse handshakes
// (available/read, allowed/write) and the valid/ready streams of the
// effects core. Mic samples pass through a single pipeline register;
// processed samples return through a small circular FIFO.
// Optional feature macro: BRIDGE_MONO_SUM_EN (mono downmix on capture).

module audio_codec_bridge #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic                          audio_in_available,
  output logic                          read_audio_in,
  input  logic [DATA_W-1:0]             codec_in_L,
  input  logic [DATA_W-1:0]             codec_in_R,
  input  logic                          audio_out_allowed,
  output logic                          write_audio_out,
  output logic [DATA_W-1:0]             codec_out_L,
  output logic [DATA_W-1:0]             codec_out_R,
  output logic                          src_valid,
  input  logic                          src_ready,
  output logic [DATA_W-1:0]             src_L,
  output logic [DATA_W-1:0]             src_R,
  input  logic                          snk_valid,
  output logic                          snk_ready,
  input  logic [DATA_W-1:0]             snk_L,
  input  logic [DATA_W-1:0]             snk_R,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic {IN_EMPTY, IN_HOLD} in_state_t;

  in_state_t         state;
  in_state_t         state_next;
  logic              run;
  logic [DATA_W-1:0] load_L;
  logic [DATA_W-1:0] load_R;

  logic [DATA_W-1:0] mem_L [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_R [FIFO_DEPTH];
  logic [DATA_W-1:0] last_L;
  logic [DATA_W-1:0] last_R;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic              push;
  logic              pop;

  // Strobes stay quiet until one full clock has passed after reset release,
  // so a release in the middle of a controller transfer cannot glitch a pop.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) run <= 1'b0;
    else          run <= 1'b1;
  end

  assign src_valid     = (state == IN_HOLD);
  assign read_audio_in = run & audio_in_available & (~src_valid | src_ready) & ~clear;

`ifdef BRIDGE_MONO_SUM_EN
  logic signed [DATA_W:0] mono_sum;

  // Mono downmix: widened sum then floor-halving, so the result can never overflow.
  always_comb begin
    mono_sum = $signed({codec_in_L[DATA_W-1], codec_in_L}) +
               $signed({codec_in_R[DATA_W-1], codec_in_R});
    load_L   = DATA_W'(mono_sum >>> 1);
    load_R   = DATA_W'(mono_sum >>> 1);
  end
`else
  assign load_L = codec_in_L;
  assign load_R = codec_in_R;
`endif

  // Input stage state register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= IN_EMPTY;
    else          state <= state_next;
  end

  // Input stage next state: load on a pop strobe, drain when the core takes the pair.
  always_comb begin
    state_next = state;
    if (clear)                                 state_next = IN_EMPTY;
    else if (read_audio_in)                    state_next = IN_HOLD;
    else if ((state == IN_HOLD) && src_ready)  state_next = IN_EMPTY;
  end

  // Input pipeline data register, loaded only when a sample is popped from the controller.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      src_L <= '0;
      src_R <= '0;
    end else if (read_audio_in) begin
      src_L <= load_L;
      src_R <= load_R;
    end
  end

  // Ready depends only on the registered level, never on a same-cycle pop.
  assign snk_ready       = run & (level != FULL_LEVEL) & ~clear;
  assign write_audio_out = run & (level != '0) & audio_out_allowed & ~clear;
  assign push            = snk_valid & snk_ready;
  assign pop             = write_audio_out;
  assign fifo_level      = level;

  // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= rd_ptr;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // FIFO storage written at the write pointer on each accepted processed pair.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_L[i] <= '0;
        mem_R[i] <= '0;
      end
    end else if (push) begin
      mem_L[wr_ptr] <= snk_L;
      mem_R[wr_ptr] <= snk_R;
    end
  end

  // Copy of the most recently popped pair, shown on the DAC bus while the FIFO is empty.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      last_L <= '0;
      last_R <= '0;
    end else if (pop) begin
      last_L <= mem_L[rd_ptr];
      last_R <= mem_R[rd_ptr];
    end
  end

  assign codec_out_L = (level != '0) ? mem_L[rd_ptr] : last_L;
  assign codec_out_R = (level != '0) ? mem_R[rd_ptr] : last_R;

endmodule

// File: tb/tb_audio_codec_bridge.sv
// tb_audio_codec_bridge
// Directed bench with scoreboard queues for the mic (source) path and the
// DAC (FIFO) path. Honours BRIDGE_MONO_SUM_EN when defined.

module tb_audio_codec_bridge;

  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;

  logic              clk;
  logic              reset_n;
  logic              clear;
  logic              audio_in_available;
  logic              read_audio_in;
  logic [DATA_W-1:0] codec_in_L;
  logic [DATA_W-1:0] codec_in_R;
  logic              audio_out_allowed;
  logic              write_audio_out;
  logic [DATA_W-1:0] codec_out_L;
  logic [DATA_W-1:0] codec_out_R;
  logic              src_valid;
  logic              src_ready;
  logic [DATA_W-1:0] src_L;
  logic [DATA_W-1:0] src_R;
  logic              snk_valid;
  logic              snk_ready;
  logic [DATA_W-1:0] snk_L;
  logic [DATA_W-1:0] snk_R;
  logic [2:0]        fifo_level;

  int checks = 0;
  int errors = 0;
  int read_count = 0;
  int write_count = 0;
  int base_reads;
  int base_writes;
  logic [63:0] src_q [$];
  logic [63:0] fifo_q [$];

  audio_codec_bridge #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLOCK_50(clk), .reset_n(reset_n), .clear(clear),
    .audio_in_available(audio_in_available), .read_audio_in(read_audio_in),
    .codec_in_L(codec_in_L), .codec_in_R(codec_in_R),
    .audio_out_allowed(audio_out_allowed), .write_audio_out(write_audio_out),
    .codec_out_L(codec_out_L), .codec_out_R(codec_out_R),
    .src_valid(src_valid), .src_ready(src_ready), .src_L(src_L), .src_R(src_R),
    .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_L(snk_L), .snk_R(snk_R),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected src pair for a captured codec pair.
  function automatic logic [63:0] modelSrc(input logic [31:0] l, input logic [31:0] r);
`ifdef BRIDGE_MONO_SUM_EN
    logic signed [32:0] s;
    s = $signed({l[31], l}) + $signed({r[31], r});
    return {s[32:1], s[32:1]};
`else
    return {l, r};
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, return at the falling edge.
  task automatic applyStimulus(input logic avail, input logic [31:0] in_l, input logic [31:0] in_r,
                               input logic srdy, input logic svalid, input logic [31:0] s_l,
                               input logic [31:0] s_r, input logic allowed, input logic clr);
    @(posedge clk);
    #1;
    audio_in_available = avail;
    codec_in_L         = in_l;
    codec_in_R         = in_r;
    src_ready          = srdy;
    snk_valid          = svalid;
    snk_L              = s_l;
    snk_R              = s_r;
    audio_out_allowed  = allowed;
    clear              = clr;
    @(negedge clk);
  endtask

  // Scoreboard monitors: compare every handshake against the queued expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (read_audio_in === 1'b1)   read_count++;
      if (write_audio_out === 1'b1) write_count++;
      if (src_valid === 1'b1 && src_ready === 1'b1) begin
        if (src_q.size() == 0) checkOutput("src_unexpected", 64'd1, 64'd0);
        else checkOutput("src_pair", {src_L, src_R}, src_q.pop_front());
      end
      if (write_audio_out === 1'b1) begin
        if (fifo_q.size() == 0) checkOutput("dac_unexpected", 64'd1, 64'd0);
        else checkOutput("dac_pair", {codec_out_L, codec_out_R}, fifo_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 1'b0;
    clear = 1'b0;
    audio_in_available = 1'b1;
    audio_out_allowed = 1'b1;
    snk_valid = 1'b1;
    codec_in_L = 32'h1111_1111;
    codec_in_R = 32'h2222_2222;
    snk_L = 32'h3333_3333;
    snk_R = 32'h4444_4444;
    src_ready = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_read", read_audio_in, 0);
    checkOutput("rst_write", write_audio_out, 0);
    checkOutput("rst_snk_ready", snk_ready, 0);
    checkOutput("rst_src_valid", src_valid, 0);
    checkOutput("rst_src", {src_L, src_R}, 0);
    checkOutput("rst_level", fifo_level, 0);
    checkOutput("rst_codec_out", {codec_out_L, codec_out_R}, 0);

    audio_in_available = 1'b0;
    audio_out_allowed = 1'b0;
    snk_valid = 1'b0;
    reset_n = 1'b1;
    #1;
    checkOutput("release_snk_ready", snk_ready, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("run_snk_ready", snk_ready, 1);

    $display("[TB] single sample");
    applyStimulus(1, 32'h0012_3456, 32'hFFED_CBAA, 1, 0, 0, 0, 0, 0);
    checkOutput("single_read", read_audio_in, 1);
    src_q.push_back(modelSrc(32'h0012_3456, 32'hFFED_CBAA));
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("single_read_off", read_audio_in, 0);
    checkOutput("single_valid", src_valid, 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("single_valid_off", src_valid, 0);

    $display("[TB] backpressure");
    base_reads = read_count;
    applyStimulus(1, 32'hA1A1_0001, 32'hB1B1_0001, 0, 0, 0, 0, 0, 0);
    checkOutput("bp_first_read", read_audio_in, 1);
    src_q.push_back(modelSrc(32'hA1A1_0001, 32'hB1B1_0001));
    for (int i = 1; i < 10; i++) begin
      applyStimulus(1, 32'h1000 + i, 32'h2000 + i, 0, 0, 0, 0, 0, 0);
      checkOutput("bp_no_read", read_audio_in, 0);
    end
    checkOutput("bp_stable", {src_L, src_R}, modelSrc(32'hA1A1_0001, 32'hB1B1_0001));
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 32'h5000_0000 + k, 32'hC000_0000 - k, 1, 0, 0, 0, 0, 0);
      checkOutput("b2b_read", read_audio_in, 1);
      checkOutput("b2b_valid", src_valid, 1);
      src_q.push_back(modelSrc(32'h5000_0000 + k, 32'hC000_0000 - k));
    end
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("b2b_tail_valid", src_valid, 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("b2b_empty", src_valid, 0);
    checkOutput("bp_read_count", read_count - base_reads, 4);

    $display("[TB] fifo fill");
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 0, 0, 0, 1, i, 32'(0 - i), 0, 0);
      checkOutput("fill_snk_ready", snk_ready, (i <= FIFO_DEPTH) ? 1 : 0);
      if (i <= FIFO_DEPTH) fifo_q.push_back({32'(i), 32'(0 - i)});
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("full_level", fifo_level, 4);
    checkOutput("full_snk_ready", snk_ready, 0);
    checkOutput("full_no_write", write_audio_out, 0);
    base_writes = write_count;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput("drain_write", write_audio_out, 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("drained_write", write_audio_out, 0);
    checkOutput("drained_level", fifo_level, 0);
    checkOutput("stale_out", {codec_out_L, codec_out_R}, {32'd4, 32'(0 - 4)});
    checkOutput("drain_write_count", write_count - base_writes, 4);

    $display("[TB] simultaneous push/pop");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 32'd10 + i, 32'hF000 + i, 0, 0);
      fifo_q.push_back({32'd10 + 32'(i), 32'hF000 + 32'(i)});
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 32'd12 + i, 32'hF002 + i, 1, 0);
      checkOutput("pp_level", fifo_level, 2);
      checkOutput("pp_write", write_audio_out, 1);
      checkOutput("pp_snk_ready", snk_ready, 1);
      fifo_q.push_back({32'd12 + 32'(i), 32'hF002 + 32'(i)});
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput("pp_drain_write", write_audio_out, 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("pp_empty_level", fifo_level, 0);

    $display("[TB] saturation vectors");
    applyStimulus(1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1, 0, 0, 0, 0, 0);
    src_q.push_back(modelSrc(32'h7FFF_FFFF, 32'h7FFF_FFFF));
    applyStimulus(1, 32'hFFFF_FFFD, 32'h0, 1, 0, 0, 0, 0, 0);
    src_q.push_back(modelSrc(32'hFFFF_FFFD, 32'h0));
`ifdef BRIDGE_MONO_SUM_EN
    checkOutput("mono_max", {src_L, src_R}, {32'h7FFF_FFFF, 32'h7FFF_FFFF});
`else
    checkOutput("pass_max", {src_L, src_R}, {32'h7FFF_FFFF, 32'h7FFF_FFFF});
`endif
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
`ifdef BRIDGE_MONO_SUM_EN
    checkOutput("mono_floor", {src_L, src_R}, {32'hFFFF_FFFE, 32'hFFFF_FFFE});
`else
    checkOutput("pass_neg", {src_L, src_R}, {32'hFFFF_FFFD, 32'h0});
`endif
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] clear mid-stream");
    applyStimulus(1, 32'hDEAD_0001, 32'hBEEF_0001, 0, 1, 32'd30, 32'd130, 0, 0);
    checkOutput("clr_pre_read", read_audio_in, 1);
    applyStimulus(0, 0, 0, 0, 1, 32'd31, 32'd131, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'd32, 32'd132, 0, 0);
    applyStimulus(1, 32'hDEAD_0002, 32'hBEEF_0002, 0, 1, 32'd33, 32'd133, 1, 1);
    checkOutput("clr_level_before", fifo_level, 3);
    checkOutput("clr_valid_before", src_valid, 1);
    checkOutput("clr_read", read_audio_in, 0);
    checkOutput("clr_write", write_audio_out, 0);
    checkOutput("clr_snk_ready", snk_ready, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("clr_valid_after", src_valid, 0);
    checkOutput("clr_level_after", fifo_level, 0);

    $display("[TB] async reset mid-write");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 32'd40 + i, 32'd140 + i, 0, 0);
      fifo_q.push_back({32'd40 + 32'(i), 32'd140 + 32'(i)});
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("ar_write", write_audio_out, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("ar_write_off", write_audio_out, 0);
    checkOutput("ar_level", fifo_level, 0);
    checkOutput("ar_codec_out", {codec_out_L, codec_out_R}, 0);
    checkOutput("ar_snk_ready", snk_ready, 0);
    checkOutput("ar_src", {src_L, src_R, 31'd0, src_valid}, 0);
    fifo_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    checkOutput("src_q_drained", src_q.size(), 0);
    checkOutput("fifo_q_drained", fifo_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_codec_bridge.md
Name: audio_codec_bridge

Overview:
- Stream adapter between the codec-side Audio_Controller sample ports and the effects core.
- Converts the controller's available/read and allowed/write pulse handshakes into valid/ready streams.
- Source stream carries mic samples towards the effects core; sink stream carries processed samples back through a small output FIFO.
- Captures each codec sample exactly once, and writes each processed sample exactly once.

Parameters:
- DATA_W, 32: sample width per channel, two's-complement signed.
- FIFO_DEPTH, 4: output FIFO entries; power of two, at least 2.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; active high.
- audio_in_available  in  1  controller has a mic sample pair.
- read_audio_in  out  1  one-cycle pop strobe to controller.
- codec_in_L / codec_in_R  in  DATA_W  controller head mic samples.
- audio_out_allowed  in  1  controller has DAC space.
- write_audio_out  out  1  one-cycle push strobe to controller.
- codec_out_L / codec_out_R  out  DATA_W  DAC samples; valid while write_audio_out is high.
- src_valid  out  1  mic sample pair presented to the effects core.
- src_ready  in  1  effects core accepts the pair.
- src_L / src_R  out  DATA_W  mic sample pair.
- snk_valid  in  1  effects core offers a processed pair.
- snk_ready  out  1  bridge accepts the pair.
- snk_L / snk_R  in  DATA_W  processed pair.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  output FIFO occupancy.

Behaviour:
- Reset (reset_n=0, async): src_valid=0, src_L=src_R=0, FIFO empty, fifo_level=0, read_audio_in=0, write_audio_out=0, snk_ready=0, codec_out_L=codec_out_R=0.
- Reset released mid-transfer: no strobe is issued until the first full clock after release.
- Input stage: single pipeline register, two states, EMPTY (src_valid=0) and HOLD (src_valid=1).
  - read_audio_in = audio_in_available & (~src_valid | src_ready) & ~clear; combinational, and it may only be asserted when that condition holds.
  - On a read_audio_in cycle, codec_in_L/R are registered into src_L/R and src_valid=1 on the next edge. Latency is codec sample to src_valid in 1 cycle.
  - HOLD with src_ready=1 and audio_in_available=1: back-to-back, pop and reload on the same edge, src_valid stays 1.
  - HOLD with src_ready=1 and no new sample available: go to EMPTY.
  - HOLD with src_ready=0: src_L/R and src_valid are held stable. Samples are never overwritten or dropped by the bridge.
- Output stage FIFO, depth FIFO_DEPTH, circular read/write pointers:
  - snk_ready = (fifo_level != FIFO_DEPTH) & ~clear. No combinational path from pop to snk_ready; a full FIFO refuses a push even in a cycle that also pops.
  - Push on snk_valid & snk_ready.
  - write_audio_out = (fifo_level != 0) & audio_out_allowed & ~clear. codec_out_L/R always show the FIFO head (registered storage). Pop on write_audio_out.
  - Simultaneous push and pop: level unchanged, pointers both advance. Pointers wrap at FIFO_DEPTH with no special case.
  - Empty: write_audio_out=0. codec_out_L/R hold the last popped entry (stale, not zero).
  - Latency: snk handshake to write_audio_out ≥ 1 cycle (FIFO registered).
- clear=1:
  - Next edge: src_valid=0 and FIFO emptied.
  - That cycle: read_audio_in=0, write_audio_out=0, snk_ready=0.
  - Data pending inside the controller is untouched.
- No arithmetic on samples unless the optional feature is enabled.

Optional Feature:
- Macro BRIDGE_MONO_SUM_EN.
  - Defined: when loading the input register, sum = sign-extended codec_in_L + codec_in_R in DATA_W+1 bits, then arithmetic shift right 1, truncated to DATA_W. src_L and src_R both carry the result, so there is no overflow (e.g. 0x7FFFFFFF + 0x7FFFFFFF gives 0x7FFFFFFF; 0x80000000 + 0x80000000 gives 0x80000000; -1 + 0 gives -1, floor rounding).
  - Undefined: src_L=codec_in_L, src_R=codec_in_R bit-exact. Timing is identical in both builds.

Test Plan:
- Single sample: release reset, audio_in_available=1 for 1 cycle with L=0x00123456, R=0xFFEDCBAA, src_ready=1 → read_audio_in high exactly that cycle; next cycle src_valid=1 with the same values; then src_valid=0.
- Backpressure: hold src_ready=0 for 10 cycles with audio_in_available=1 → exactly one read_audio_in strobe, src_L/R stable; src_ready=1 with available high → back-to-back reload, one strobe per accepted pair.
- FIFO fill: audio_out_allowed=0, push 5 pairs 1..5 with DEPTH=4 → pairs 1–4 accepted, snk_ready=0 from level 4, fifo_level=4; allowed=1 → write_audio_out for 4 cycles emitting 1,2,3,4 in order; then level 0 and no strobe.
- Simultaneous push/pop: level 2, snk_valid=1 and allowed=1 for 8 cycles → level stays 2, outputs in order across pointer wrap.
- Clear mid-stream: level 3 with src_valid=1, clear=1 one cycle → no strobes that cycle; next cycle src_valid=0, fifo_level=0. Async reset_n low mid-write likewise zeroes all outputs immediately.
- With BRIDGE_MONO_SUM_EN: L=0x7FFFFFFF, R=0x7FFFFFFF → src_L=src_R=0x7FFFFFFF; L=-3, R=0 → -2.
